// File: rtl/multiplicador_secuencial.sv
// Iterative shift-add multiplier producing the full 2*BITS product over BITS cycles.
// Optional SIGNED_MUL_EN: two's-complement operation when esSigno is captured high.
module multiplicador_secuencial #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [BITS-1:0] datoA,
  input  logic [BITS-1:0] datoB,
  input  logic            esSigno,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] resultadoLow,
  output logic [BITS-1:0] resultadoHigh
);
  localparam int CW = $clog2(BITS + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} estado_t;

  estado_t           estado;
  logic [BITS-1:0]   mcand;
  // Upper half is the running accumulator, lower half the remaining multiplier bits.
  logic [2*BITS-1:0] acc;
  logic [CW-1:0]     cnt;
  logic              neg;

  logic [BITS:0]     suma;
  logic [2*BITS-1:0] acc_nx;
  logic [2*BITS-1:0] prod;
  logic [BITS-1:0]   op_a;
  logic [BITS-1:0]   op_b;
  logic              neg_nx;

  always_comb begin
    suma   = {1'b0, acc[2*BITS-1:BITS]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_nx = {suma, acc[BITS-1:1]};
    prod   = neg ? -acc_nx : acc_nx;
`ifdef SIGNED_MUL_EN
    // The most negative value negates to itself, which is its correct unsigned magnitude.
    op_a   = (esSigno && datoA[BITS-1]) ? -datoA : datoA;
    op_b   = (esSigno && datoB[BITS-1]) ? -datoB : datoB;
    neg_nx = esSigno && (datoA[BITS-1] ^ datoB[BITS-1]);
`else
    op_a   = datoA;
    op_b   = datoB;
    neg_nx = esSigno & 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado        <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      resultadoLow  <= '0;
      resultadoHigh <= '0;
      acc           <= '0;
      cnt           <= '0;
      mcand         <= '0;
      neg           <= 1'b0;
    end else begin
      case (estado)
        IDLE, FIN: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= op_a;
            acc    <= {{BITS{1'b0}}, op_b};
            cnt    <= CW'(BITS);
            neg    <= neg_nx;
            busy   <= 1'b1;
            estado <= RUN;
          end else begin
            estado <= IDLE;
          end
        end
        RUN: begin
          acc <= acc_nx;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            estado                        <= FIN;
            busy                          <= 1'b0;
            done                          <= 1'b1;
            {resultadoHigh, resultadoLow} <= prod;
          end
        end
        default: estado <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Directed bench for multiplicador_secuencial: vector table plus handshake corner sequences.
module tb_multiplicador_secuencial;
  logic        clk = 1'b0;
  logic        rst, start, esSigno;
  logic [31:0] datoA, datoB;
  logic        busy, done;
  logic [31:0] resultadoLow, resultadoHigh;

  int checks = 0;
  int errors = 0;
  logic [63:0] last_p = '0;

  multiplicador_secuencial #(.BITS(32)) dut (
    .clk(clk), .rst(rst), .start(start), .datoA(datoA), .datoB(datoB),
    .esSigno(esSigno), .busy(busy), .done(done),
    .resultadoLow(resultadoLow), .resultadoHigh(resultadoHigh)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one multiply from idle and follow it to completion.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [63:0] exp, input string name);
    int lat, bcnt;
    lat = 0; bcnt = 0;
    @(negedge clk);
    start = 1'b1; datoA = a; datoB = b; esSigno = s;
    @(posedge clk); #1;
    start = 1'b0; datoA = $urandom; datoB = $urandom; esSigno = 1'b0;
    @(negedge clk);
    check({name, " hold_on_accept"}, {resultadoHigh, resultadoLow}, last_p);
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) @(negedge clk);
      if (busy) bcnt++;
      if (done) begin lat = c; break; end
    end
    check({name, " latency"}, 64'(lat), 64'd33);
    check({name, " busy_cycles"}, 64'(bcnt), 64'd32);
    check({name, " product"}, {resultadoHigh, resultadoLow}, exp);
    last_p = exp;
    @(negedge clk);
    check({name, " done_single"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int dcnt;
    logic ok;
    tbl[0] = '{32'd3, 32'd5, 1'b0, 64'h0000000F};
    tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001};
    tbl[2] = '{32'h00010000, 32'h00010000, 1'b0, 64'h00000001_00000000};
    tbl[3] = '{32'hFFFFFFFF, 32'd2, 1'b0, 64'h00000001_FFFFFFFE};
    tbl[4] = '{32'd3, 32'd5, 1'b1, 64'h0000000F};
    tbl[5] = '{32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000};
`ifdef SIGNED_MUL_EN
    tbl[6] = '{32'hFFFFFFFD, 32'd5, 1'b1, 64'hFFFFFFFF_FFFFFFF1};
    tbl[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001};
    tbl[8] = '{32'd7, 32'hFFFFFFFE, 1'b1, 64'hFFFFFFFF_FFFFFFF2};
`else
    tbl[6] = '{32'hFFFFFFFD, 32'd5, 1'b1, 64'h00000004_FFFFFFF1};
    tbl[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFE_00000001};
    tbl[8] = '{32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000006_FFFFFFF2};
`endif

    rst = 1'b1; start = 1'b0; esSigno = 1'b0; datoA = '0; datoB = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset result", {resultadoHigh, resultadoLow}, 64'd0);

    foreach (tbl[i]) do_mul(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].exp, $sformatf("vec%0d", i));

    // Start while busy is ignored, then back-to-back start in the done cycle.
    @(negedge clk);
    start = 1'b1; datoA = 32'd7; datoB = 32'd6; esSigno = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1; datoA = 32'd100; datoB = 32'd9;
    @(posedge clk); #1 start = 1'b0;
    dcnt = 0; ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done) begin dcnt++; ok = 1'b1; break; end
    end
    check("busy_start done_seen", {63'd0, ok}, 64'd1);
    check("busy_start product", {resultadoHigh, resultadoLow}, 64'h2A);
    start = 1'b1; datoA = 32'd2; datoB = 32'd2;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("b2b busy", {63'd0, busy}, 64'd1);
    check("b2b done_low", {63'd0, done}, 64'd0);
    check("b2b hold", {resultadoHigh, resultadoLow}, 64'h2A);
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done) begin dcnt++; ok = 1'b1; break; end
    end
    check("b2b done_seen", {63'd0, ok}, 64'd1);
    check("b2b product", {resultadoHigh, resultadoLow}, 64'd4);
    check("done_pulses", 64'(dcnt), 64'd2);
    last_p = 64'd4;
    @(negedge clk);

    // Reset in the middle of a run.
    start = 1'b1; datoA = 32'd9; datoB = 32'd9;
    @(posedge clk); #1 start = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst busy", {63'd0, busy}, 64'd0);
    check("midrst done", {63'd0, done}, 64'd0);
    check("midrst result", {resultadoHigh, resultadoLow}, 64'd0);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("midrst no_activity", 64'(dcnt), 64'd0);
    last_p = '0;
    do_mul(32'd2, 32'd3, 1'b0, 64'd6, "after_rst");

    // Zero product, then idle hold with noisy operands.
    do_mul(32'd0, 32'h12345678, 1'b0, 64'd0, "zero");
    dcnt = 0;
    repeat (20) begin
      @(negedge clk);
      datoA = $urandom; datoB = $urandom; esSigno = 1'($urandom);
      if (done || busy || ({resultadoHigh, resultadoLow} != 64'd0)) dcnt++;
    end
    check("idle_hold", 64'(dcnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
